// File: rtl/expr_seq_ctrl.sv
// Sequencing controller: consumes ASCII single-digit expressions ('*' over '+', '=' ends),
// presents one result or error per expression. Optional subtraction under EXPR_SUB_EN.
module expr_seq_ctrl #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         clr,
   input  logic [7:0]   in,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] res,
   output logic         res_valid,
   input  logic         res_ready,
   output logic         err,
   output logic         busy
);

   typedef enum logic [1:0] {StDig, StOp, StErr, StOut} state_e;

   state_e       state_q, state_d;
   logic [W-1:0] sum_q, sum_d;
   logic [W-1:0] term_q, term_d;
   logic         mul_q, mul_d;
   logic         neg_q, neg_d;
   logic [W-1:0] res_q, res_d;
   logic         err_q, err_d;
   logic         valid_q, valid_d;
   logic         busy_q, busy_d;

   logic         accept;
   logic         is_dig, is_add, is_mul, is_eq, is_sub;
   logic [7:0]   dig_val;
   logic [W-1:0] term_signed;

   assign is_dig  = (in >= 8'h30) && (in <= 8'h39);
   assign is_add  = (in == 8'h2B);
   assign is_mul  = (in == 8'h2A);
   assign is_eq   = (in == 8'h3D);
   assign dig_val = in - 8'h30;

`ifdef EXPR_SUB_EN
   assign is_sub      = (in == 8'h2D);
   assign term_signed = neg_q ? (~term_q + W'(1)) : term_q;
`else
   assign is_sub      = 1'b0;
   assign term_signed = term_q;
`endif

   assign in_ready  = (state_q != StOut);
   assign accept    = in_valid && in_ready;
   assign res       = res_q;
   assign res_valid = valid_q;
   assign err       = err_q;
   assign busy      = busy_q;

   always_comb begin
      state_d = state_q;
      sum_d   = sum_q;
      term_d  = term_q;
      mul_d   = mul_q;
      neg_d   = neg_q;
      res_d   = res_q;
      err_d   = err_q;
      valid_d = valid_q;
      busy_d  = busy_q;

      // Any accepted character except a terminating '=' keeps the expression open.
      if (accept) busy_d = 1'b1;

      unique case (state_q)
         StDig: begin
            if (accept) begin
               if (is_dig) begin
                  term_d  = mul_q ? (term_q * W'(dig_val)) : W'(dig_val);
                  mul_d   = 1'b0;
                  state_d = StOp;
               end else begin
                  state_d = StErr;
               end
            end
         end
         StOp: begin
            if (accept) begin
               if (is_add || is_sub) begin
                  sum_d   = sum_q + term_signed;
                  term_d  = '0;
                  neg_d   = is_sub;
                  state_d = StDig;
               end else if (is_mul) begin
                  mul_d   = 1'b1;
                  state_d = StDig;
               end else if (is_eq) begin
                  res_d   = sum_q + term_signed;
                  err_d   = 1'b0;
                  valid_d = 1'b1;
                  busy_d  = 1'b0;
                  state_d = StOut;
               end else begin
                  state_d = StErr;
               end
            end
         end
         StErr: begin
            if (accept && is_eq) begin
               res_d   = '0;
               err_d   = 1'b1;
               valid_d = 1'b1;
               busy_d  = 1'b0;
               state_d = StOut;
            end
         end
         StOut: begin
            if (res_ready) begin
               valid_d = 1'b0;
               sum_d   = '0;
               term_d  = '0;
               mul_d   = 1'b0;
               neg_d   = 1'b0;
               state_d = StDig;
            end
         end
         default: state_d = StDig;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= StDig;
         sum_q   <= '0;
         term_q  <= '0;
         mul_q   <= 1'b0;
         neg_q   <= 1'b0;
         res_q   <= '0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sum_q   <= sum_d;
         term_q  <= term_d;
         mul_q   <= mul_d;
         neg_q   <= neg_d;
         res_q   <= res_d;
         err_q   <= err_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

endmodule

// File: tb/tb_expr_seq_ctrl.sv
// Directed bench for expr_seq_ctrl; subtraction expectations follow EXPR_SUB_EN.
module tb_expr_seq_ctrl;

   localparam int unsigned W = 16;

   logic         clk = 1'b0;
   logic         clr;
   logic [7:0]   in;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] res;
   logic         res_valid;
   logic         res_ready;
   logic         err;
   logic         busy;

   int n_checks = 0;
   int n_errors = 0;

   expr_seq_ctrl #(.W(W)) dut (
      .clk       (clk),
      .clr       (clr),
      .in        (in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .res       (res),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .err       (err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_str(input string s);
      int cnt;
      in_valid = 1'b1;
      for (int i = 0; i < s.len(); i++) begin
         in  = s[i];
         cnt = 0;
         while (!in_ready && cnt < 20) begin
            tick();
            cnt++;
         end
         if (cnt >= 20) check_eq("in_ready_timeout", 32'(in_ready), 32'd1);
         tick();
      end
      in_valid = 1'b0;
      in       = 8'h00;
   endtask

   // Expects the result already presented, accepts it, then checks the rearm.
   task automatic take_result(input string tag, input logic [W-1:0] exp_res, input logic exp_err);
      check_eq({tag, "_valid"}, 32'(res_valid), 32'd1);
      check_eq({tag, "_res"}, 32'(res), 32'(exp_res));
      check_eq({tag, "_err"}, 32'(err), 32'(exp_err));
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check_eq({tag, "_valid_drop"}, 32'(res_valid), 32'd0);
      check_eq({tag, "_rearm"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      clr       = 1'b1;
      in        = 8'h00;
      in_valid  = 1'b0;
      res_ready = 1'b0;
      tick();
      tick();
      clr = 1'b0;
      check_eq("rst_res", 32'(res), 32'd0);
      check_eq("rst_valid", 32'(res_valid), 32'd0);
      check_eq("rst_err", 32'(err), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_in_ready", 32'(in_ready), 32'd1);

      send_str("1+2*");
      check_eq("busy_mid", 32'(busy), 32'd1);
      send_str("3=");
      check_eq("prec_hold_ready", 32'(in_ready), 32'd0);
      take_result("prec", 16'd7, 1'b0);

      send_str("2*3*4+5=");
      take_result("chain", 16'd29, 1'b0);
      send_str("9*9*9*9*9*9=");
      take_result("wrap", 16'd7153, 1'b0);

      send_str("1++2=");
      take_result("dbl_op", 16'd0, 1'b1);
      tick();
      tick();
      check_eq("dbl_op_single", 32'(res_valid), 32'd0);
      send_str("12=");
      take_result("multi_dig", 16'd0, 1'b1);
      // Lone '=' sends the controller into discard; the second '=' ends it.
      send_str("=");
      check_eq("empty_no_res", 32'(res_valid), 32'd0);
      check_eq("empty_busy", 32'(busy), 32'd1);
      send_str("=");
      take_result("empty", 16'd0, 1'b1);
      send_str("3+a=");
      take_result("bad_char", 16'd0, 1'b1);

      send_str("4*2=");
      for (int i = 0; i < 5; i++) begin
         check_eq("bp_res", 32'(res), 32'd8);
         check_eq("bp_valid", 32'(res_valid), 32'd1);
         check_eq("bp_in_ready", 32'(in_ready), 32'd0);
         tick();
      end
      take_result("bp", 16'd8, 1'b0);
      send_str("1=");
      take_result("after_bp", 16'd1, 1'b0);

      send_str("1+2*");
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check_eq("abort_busy", 32'(busy), 32'd0);
      check_eq("abort_valid", 32'(res_valid), 32'd0);
      check_eq("abort_ready", 32'(in_ready), 32'd1);
      send_str("5=");
      take_result("abort", 16'd5, 1'b0);

      send_str("5-2*3=");
`ifdef EXPR_SUB_EN
      take_result("sub", 16'hFFFF, 1'b0);
`else
      take_result("sub", 16'd0, 1'b1);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
